// File: rtl/multicycle_cla.sv
// multicycle_cla: add/subtract with carry lookahead, one SLICE-bit slice per clock, under valid/ready handshake.
// Each slice is a flat carry-lookahead block. The carry register links one slice to the next.
module multicycle_cla #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overflow,
    output logic             isZero,
    output logic [WIDTH-1:0] bw_and,
    output logic [WIDTH-1:0] bw_or
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_r, b_r, s_next;
    logic [KW-1:0] k;
    logic c_r, t;
    logic [SLICE-1:0] sa, sb, g, p;
    logic [SLICE:0] c;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sa = a_r[int'(k)*SLICE +: SLICE];
    assign sb = b_r[int'(k)*SLICE +: SLICE];
    assign g  = sa & sb;
    assign p  = sa ^ sb;

    // Each carry is a flat sum of products of g/p terms. It does not depend on c[i-1].
    always_comb begin
        c = '0;
        t = 1'b0;
        for (int i = 0; i <= SLICE; i++) begin
            t = c_r;
            for (int j = 0; j < i; j++) t = t & p[j];
            c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int l = j + 1; l < i; l++) t = t & p[l];
                c[i] = c[i] | t;
            end
        end
        s_next = S;
        s_next[int'(k)*SLICE +: SLICE] = p ^ c[SLICE-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            c_r      <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            S        <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
            isZero   <= 1'b0;
            bw_and   <= '0;
            bw_or    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r    <= A;
                    b_r    <= sub ? ~B : B;
                    c_r    <= sub | cin;
                    S      <= '0;
                    k      <= '0;
                    bw_and <= A & B;
                    bw_or  <= A | B;
                    state  <= RUN;
                end
                RUN: begin
                    S   <= s_next;
                    c_r <= c[SLICE];
                    k   <= k + 1'b1;
                    if (k == KW'(NSLICE - 1)) begin
                        Cout     <= c[SLICE];
                        overflow <= c[SLICE] ^ c[SLICE-1];
                        isZero   <= s_next == '0;
                        state    <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_cla.sv
// tb_multicycle_cla: three instances (32/8, 16/4, 8/8). Results are checked against directed vectors and against a signed/unsigned arithmetic model.
module tb_multicycle_cla;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [31:0] a_in, b_in;
    logic cin, sub;
    logic [2:0] iv, ordy, irdy, ovld, co, ovf, iz;
    logic [31:0] s0, an0, or0;
    logic [15:0] s1, an1, or1;
    logic [7:0]  s2, an2, or2;
    logic [31:0] s_o[3], an_o[3], or_o[3];
    int ncmp = 0, nerr = 0;

    assign s_o[0] = s0;
    assign s_o[1] = {16'h0, s1};
    assign s_o[2] = {24'h0, s2};
    assign an_o[0] = an0;
    assign an_o[1] = {16'h0, an1};
    assign an_o[2] = {24'h0, an2};
    assign or_o[0] = or0;
    assign or_o[1] = {16'h0, or1};
    assign or_o[2] = {24'h0, or2};

    multicycle_cla #(.WIDTH(32), .SLICE(8)) u0 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .A(a_in), .B(b_in),
        .cin(cin), .sub(sub), .out_valid(ovld[0]), .out_ready(ordy[0]), .S(s0), .Cout(co[0]),
        .overflow(ovf[0]), .isZero(iz[0]), .bw_and(an0), .bw_or(or0));
    multicycle_cla #(.WIDTH(16), .SLICE(4)) u1 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .A(a_in[15:0]), .B(b_in[15:0]),
        .cin(cin), .sub(sub), .out_valid(ovld[1]), .out_ready(ordy[1]), .S(s1), .Cout(co[1]),
        .overflow(ovf[1]), .isZero(iz[1]), .bw_and(an1), .bw_or(or1));
    multicycle_cla #(.WIDTH(8), .SLICE(8)) u2 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .A(a_in[7:0]), .B(b_in[7:0]),
        .cin(cin), .sub(sub), .out_valid(ovld[2]), .out_ready(ordy[2]), .S(s2), .Cout(co[2]),
        .overflow(ovf[2]), .isZero(iz[2]), .bw_and(an2), .bw_or(or2));

    typedef struct {
        int i;
        logic [31:0] a, b;
        logic c, sb;
        logic [31:0] s;
        logic co, ov, z;
        logic [31:0] an, orr;
    } vec_t;
    vec_t tbl[10];

    function automatic int wid(input int i);
        return i == 0 ? 32 : i == 1 ? 16 : 8;
    endfunction

    function automatic int nsl(input int i);
        return i == 2 ? 1 : 4;
    endfunction

    // Reference model: mathematical sum or difference, with overflow taken from the signed range.
    function automatic void model(input int w, input longint unsigned a, b, input logic c, sb,
                                  output longint unsigned s, output logic co_e, ov_e, z_e);
        longint unsigned m;
        longint as, bs, r, lo, hi;
        m  = (64'd1 << w) - 1;
        as = a[w-1] ? longint'(a) - longint'(m) - 1 : longint'(a);
        bs = b[w-1] ? longint'(b) - longint'(m) - 1 : longint'(b);
        lo = -(longint'(1) <<< (w - 1));
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (sb) begin
            s    = (a - b) & m;
            co_e = a >= b;
            r    = as - bs;
        end else begin
            s    = (a + b + longint'(c)) & m;
            co_e = ((a + b + longint'(c)) >> w) != 0;
            r    = as + bs + longint'(c);
        end
        ov_e = r < lo || r > hi;
        z_e  = s == 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic op(input int i, input logic [31:0] a, b, input logic c, sb,
                      input logic [31:0] es, input logic eco, eov, ez, input logic [31:0] ean, eor,
                      input string tag);
        int n;
        chk({tag, " in_ready idle"}, 64'(irdy[i]), 1);
        a_in = a; b_in = b; cin = c; sub = sb; iv[i] = 1'b1;
        tick;
        iv[i] = 1'b0;
        chk({tag, " run handshake"}, {62'h0, irdy[i], ovld[i]}, 0);
        n = 0;
        while (!ovld[i] && n < 20) begin
            iv[i] = 1'($urandom_range(0, 1));
            ordy[i] = 1'($urandom_range(0, 1));
            a_in = $urandom; b_in = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            tick;
            n++;
        end
        iv[i] = 1'b0;
        ordy[i] = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(nsl(i)));
        chk({tag, " S"}, 64'(s_o[i]), 64'(es));
        chk({tag, " Cout"}, 64'(co[i]), 64'(eco));
        chk({tag, " overflow"}, 64'(ovf[i]), 64'(eov));
        chk({tag, " isZero"}, 64'(iz[i]), 64'(ez));
        chk({tag, " bw_and"}, 64'(an_o[i]), 64'(ean));
        chk({tag, " bw_or"}, 64'(or_o[i]), 64'(eor));
        ordy[i] = 1'b1;
        tick;
        ordy[i] = 1'b0;
        chk({tag, " release"}, {62'h0, irdy[i], ovld[i]}, 2);
    endtask

    initial begin
        longint unsigned m, es;
        logic eco, eov, ez, c, sb;
        logic [31:0] a, b;
        iv = '0; ordy = '0; a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        tbl[0] = '{0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1, 32'hFFFFFFFF};
        tbl[1] = '{0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h1, 32'h7FFFFFFF};
        tbl[2] = '{0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'hEFF1EFF0, 1'b1, 1'b0, 1'b0, 32'hF000F000, 32'hFFF0FFF0};
        tbl[3] = '{0, 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h5, 32'h7};
        tbl[4] = '{0, 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0, 32'h80000001};
        tbl[5] = '{0, 32'h7, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h5, 32'h7};
        tbl[6] = '{1, 32'h7FFF, 32'h1, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0, 32'h1, 32'h7FFF};
        tbl[7] = '{2, 32'hFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1, 32'hFF};
        tbl[8] = '{1, 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0, 32'h5, 32'h7};
        tbl[9] = '{0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF};

        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("reset S", 64'(s_o[i]), 0);
            chk("reset bw", {an_o[i], or_o[i]}, 0);
            chk("reset flags", {61'h0, co[i], ovf[i], iz[i]}, 0);
            chk("reset handshake", {62'h0, irdy[i], ovld[i]}, 2);
        end
        reset = 1'b0;

        foreach (tbl[v])
            op(tbl[v].i, tbl[v].a, tbl[v].b, tbl[v].c, tbl[v].sb, tbl[v].s, tbl[v].co,
               tbl[v].ov, tbl[v].z, tbl[v].an, tbl[v].orr, "table");

        // A result held in DONE must not be disturbed by a new request until the consumer releases it.
        a_in = 32'd3; b_in = 32'd4; cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
        tick;
        iv[0] = 1'b0;
        repeat (4) tick;
        chk("hold first done", 64'(ovld[0]), 1);
        iv[0] = 1'b1; a_in = 32'd100;
        for (int n = 0; n < 3; n++) begin
            tick;
            chk("hold handshake", {62'h0, irdy[0], ovld[0]}, 1);
            chk("hold S", 64'(s_o[0]), 7);
            chk("hold bw", {an_o[0], or_o[0]}, {32'h0, 32'h7});
        end
        ordy[0] = 1'b1;
        tick;
        ordy[0] = 1'b0;
        chk("hold release idle", {62'h0, irdy[0], ovld[0]}, 2);
        tick;
        iv[0] = 1'b0;
        chk("hold late accept", {62'h0, irdy[0], ovld[0]}, 0);
        repeat (3) tick;
        chk("hold second not early", 64'(ovld[0]), 0);
        tick;
        chk("hold second done", 64'(ovld[0]), 1);
        chk("hold second S", 64'(s_o[0]), 104);
        ordy[0] = 1'b1;
        tick;
        ordy[0] = 1'b0;

        a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF; iv[0] = 1'b1;
        tick;
        iv[0] = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrun reset handshake", {62'h0, irdy[0], ovld[0]}, 2);
        chk("midrun reset S", 64'(s_o[0]), 0);
        chk("midrun reset bw", {an_o[0], or_o[0]}, 0);
        chk("midrun reset flags", {61'h0, co[0], ovf[0], iz[0]}, 0);
        op(0, 32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h21436588, 1'b0, 1'b0, 1'b0,
           32'h02040608, 32'h1F3F5F7F, "after reset");

        for (int i = 0; i < 3; i++) begin
            m = (64'd1 << wid(i)) - 1;
            repeat (1000) begin
                a  = ($urandom_range(0, 7) == 0) ? 32'(m) : $urandom;
                b  = ($urandom_range(0, 7) == 0) ? 32'(m >> 1) : $urandom;
                c  = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                model(wid(i), 64'(a) & m, 64'(b) & m, c, sb, es, eco, eov, ez);
                op(i, a, b, c, sb, 32'(es), eco, eov, ez, 32'((a & b) & m), 32'((a | b) & m), "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
